mem_port_arbiter: RTL
=====================

// Module: mem_port_arbiter
// PURPOSE
// - Shares the CPU's single-port unified instruction/data memory between the IF stage (fetch, read-only)
//   and the MEM stage (loads, stores, PUSH/POP, interrupt context saves).
// - Grants one access per cycle; data side has priority, fetch is protected by an anti-starvation counter.
// - Routes synchronous-read data back to the owning requester one cycle later; IF stalls on if_req & ~if_gnt.
// PARAMETERS
// - ADDR_W      8  memory address width
// - DATA_W      8  memory data width
// - STARVE_MAX  3  consecutive denied fetch cycles before fetch is forced to win
// - LOCK_MAX    2  max consecutive locked data grants before the lock is forcibly released
// PORTS
// - clk        in   1       clock, rising edge
// - rstn       in   1       reset, synchronous, active-low
// - if_req     in   1       fetch request; req/addr held stable until if_gnt
// - if_addr    in   ADDR_W  fetch address (PC)
// - if_gnt     out  1       fetch accepted this cycle
// - if_rvalid  out  1       fetch read data valid (one cycle after if_gnt)
// - if_rdata   out  DATA_W  fetch read data
// - dm_req     in   1       data request; req/we/addr/wdata held stable until dm_gnt
// - dm_we      in   1       1 = write, 0 = read
// - dm_addr    in   ADDR_W  data address
// - dm_wdata   in   DATA_W  write data
// - dm_lock    in   1       keep port for next data access (multi-byte push/pop sequence)
// - dm_gnt     out  1       data access accepted this cycle
// - dm_rvalid  out  1       data read data valid (one cycle after a read grant)
// - dm_rdata   out  DATA_W  data read data
// - mem_en     out  1       memory access strobe
// - mem_we     out  1       memory write enable
// - mem_addr   out  ADDR_W  memory address
// - mem_wdata  out  DATA_W  memory write data
// - mem_rdata  in   DATA_W  memory read data, valid one cycle after mem_en & ~mem_we
// BEHAVIOUR
// - Reset (rstn=0 at edge): state=RUN, starve_cnt=0, lock_cnt=0, rd_owner=NONE. While rstn=0,
//   if_gnt=dm_gnt=mem_en=mem_we=0 combinationally; if_rvalid=dm_rvalid=0 from the next cycle on.
// - Grant is combinational in the request cycle; mem_* driven from winning port the same cycle.
//   Without a grant: mem_en=0, mem_we=0, mem_addr/mem_wdata=0.
// - FSM RUN: priority dm > if, except starve_cnt==STARVE_MAX -> if wins.
//   dm granted with dm_lock=1 -> LOCK, lock_cnt=1.
// - FSM LOCK: only dm may be granted; if_gnt=0 regardless of starve_cnt.
//   dm granted, dm_lock=1, lock_cnt<LOCK_MAX -> stay LOCK, lock_cnt++.
//   dm granted with dm_lock=0, or lock_cnt==LOCK_MAX -> RUN.
//   dm_req=0 -> RUN same cycle, LOCK priority not applied, RUN arbitration applies (if may be granted).
// - starve_cnt: ++ (saturating at STARVE_MAX) when if_req & ~if_gnt; cleared on if_gnt or ~if_req.
// - Read return: rd_owner register captures the granted port on a read (we=0), NONE on write/idle.
//   Next cycle the owner's rvalid=1, rdata=mem_rdata; the non-owner's rvalid=0, rdata=0.
//   Writes complete on grant and produce no rvalid.
// - Back-to-back: a new grant in the same cycle as the previous read's rvalid is legal (1 access/cycle).
// - Reset mid-transaction: a read granted in the cycle before the reset edge returns no rvalid.
// STRUCTURE
// - Shared package cpu_mem_pkg: ADDR_W/DATA_W defaults, owner enum {OWN_NONE, OWN_IF, OWN_DM},
//   arbiter state enum {ARB_RUN, ARB_LOCK}.
// - Single module; no sub-module. The CPU wrapper instantiates it between IF/MEM stages and the memory.
// TESTING
// - Fetch only: mem[0x05]=0x24, if_req addr 0x05 -> if_gnt same cycle, next cycle if_rvalid=1 rdata=0x24.
// - Contention: if_req@0x06 + dm read @0xFF -> dm_gnt=1, if_gnt=0; next cycle dm_rvalid only, if_rvalid=0.
// - Starvation: continuous dm reads + if_req, STARVE_MAX=3 -> if_gnt on 4th cycle, then dm resumes.
// - Lock: dm writes 0xFF/0xFE, dm_lock=1 on first, starve_cnt=3 -> both dm granted
//   consecutively, if_gnt on the cycle after.
// - Write/readback: dm_we=1 addr 0xFE data 0xA5 -> mem_we=1, no rvalid; later read 0xFE -> dm_rdata=0xA5.
// - Reset mid-op: dm read granted, rstn=0 next edge -> dm_rvalid stays 0, all grants 0 during reset.

Source files
------------

// File: rtl/cpu_mem_pkg.sv
// Shared definitions for the CPU memory subsystem.
// Holds the default bus widths, the read-return owner encoding and the
// memory port arbiter state encoding.
package cpu_mem_pkg;

  localparam int CPU_ADDR_W = 8;
  localparam int CPU_DATA_W = 8;

  // Which requester a pending synchronous read belongs to
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_DM   = 2'd2
  } owner_e;

  // Arbiter FSM: normal arbitration or data side holding the port
  typedef enum logic {
    ARB_RUN  = 1'b0,
    ARB_LOCK = 1'b1
  } arb_state_e;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of the fetch port, data port and single memory port that the
// arbiter sits between.
// Modports:
//   slave  - arbiter view (takes fetch/data requests and memory read data,
//            drives grants, read returns and the memory strobe/address/data)
//   master - environment view (IF/MEM stages plus the memory itself)
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8
);

  // Fetch side
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  // Data side
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic              dm_lock;
  logic              dm_gnt;
  logic              dm_rvalid;
  logic [DATA_W-1:0] dm_rdata;

  // Memory side
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_lock,
    output dm_gnt, dm_rvalid, dm_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output dm_req, dm_we, dm_addr, dm_wdata, dm_lock,
    input  dm_gnt, dm_rvalid, dm_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata
  );

endinterface

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares the single-port unified instruction/data
// memory between instruction fetch (read-only) and the MEM stage.
// One access is granted per cycle, combinationally in the request cycle.
// The data side wins by default; fetch is forced through once it has been
// denied STARVE_MAX cycles in a row. The data side may hold the port for
// multi-byte sequences with dm_lock, bounded by LOCK_MAX.
// Read data from the memory arrives one cycle after the grant and is
// steered to whichever port issued the read.
// Ports:
//   clk   - rising-edge clock
//   rstn  - synchronous active-low reset
//   bus   - fetch, data and memory signals (slave modport)
module mem_port_arbiter
  import cpu_mem_pkg::*;
#(
  parameter int ADDR_W     = CPU_ADDR_W,
  parameter int DATA_W     = CPU_DATA_W,
  parameter int STARVE_MAX = 3,
  parameter int LOCK_MAX   = 2
) (
  input  logic              clk,
  input  logic              rstn,
  mem_port_arbiter_if.slave bus
);

  localparam int STARVE_W = $clog2(STARVE_MAX + 1);
  localparam int LOCK_W   = $clog2(LOCK_MAX + 1);

  arb_state_e          state_q, state_d;
  logic [STARVE_W-1:0] starve_cnt_q, starve_cnt_d;
  logic [LOCK_W-1:0]   lock_cnt_q, lock_cnt_d;
  owner_e              rd_owner_q, rd_owner_d;

  logic if_gnt_s;
  logic dm_gnt_s;
  logic starved_s;

  // State register: FSM state, starvation/lock counters, read owner
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q      <= ARB_RUN;
      starve_cnt_q <= {STARVE_W{1'b0}};
      lock_cnt_q   <= {LOCK_W{1'b0}};
      rd_owner_q   <= OWN_NONE;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
      lock_cnt_q   <= lock_cnt_d;
      rd_owner_q   <= rd_owner_d;
    end
  end

  // Next-state logic: lock tracking, fetch starvation and read ownership
  always_comb begin
    state_d      = ARB_RUN;
    lock_cnt_d   = {LOCK_W{1'b0}};
    starve_cnt_d = {STARVE_W{1'b0}};
    rd_owner_d   = OWN_NONE;

    case (state_q)
      ARB_RUN: begin
        if (dm_gnt_s && bus.dm_lock) begin
          state_d    = ARB_LOCK;
          lock_cnt_d = LOCK_W'(1);
        end else begin
          state_d    = ARB_RUN;
          lock_cnt_d = {LOCK_W{1'b0}};
        end
      end
      ARB_LOCK: begin
        // Lock is dropped when the data side lets go, stops requesting,
        // or has used up its consecutive-grant allowance.
        if (dm_gnt_s && bus.dm_lock && (lock_cnt_q < LOCK_W'(LOCK_MAX))) begin
          state_d    = ARB_LOCK;
          lock_cnt_d = lock_cnt_q + LOCK_W'(1);
        end else begin
          state_d    = ARB_RUN;
          lock_cnt_d = {LOCK_W{1'b0}};
        end
      end
      default: begin
        state_d    = ARB_RUN;
        lock_cnt_d = {LOCK_W{1'b0}};
      end
    endcase

    // Saturating count of consecutive denied fetch cycles
    if (bus.if_req && !if_gnt_s) begin
      if (starved_s) begin
        starve_cnt_d = starve_cnt_q;
      end else begin
        starve_cnt_d = starve_cnt_q + STARVE_W'(1);
      end
    end else begin
      starve_cnt_d = {STARVE_W{1'b0}};
    end

    if (if_gnt_s) begin
      rd_owner_d = OWN_IF;
    end else if (dm_gnt_s && !bus.dm_we) begin
      rd_owner_d = OWN_DM;
    end else begin
      rd_owner_d = OWN_NONE;
    end
  end

  // Output logic: grants, memory port drive and read-data steering
  always_comb begin
    if_gnt_s  = 1'b0;
    dm_gnt_s  = 1'b0;
    starved_s = (starve_cnt_q == STARVE_W'(STARVE_MAX));

    if (!rstn) begin
      if_gnt_s = 1'b0;
      dm_gnt_s = 1'b0;
    end else if ((state_q == ARB_LOCK) && bus.dm_req) begin
      // Locked: data side keeps the port even against a starved fetch
      dm_gnt_s = 1'b1;
    end else if (bus.if_req && starved_s) begin
      if_gnt_s = 1'b1;
    end else if (bus.dm_req) begin
      dm_gnt_s = 1'b1;
    end else if (bus.if_req) begin
      if_gnt_s = 1'b1;
    end else begin
      if_gnt_s = 1'b0;
      dm_gnt_s = 1'b0;
    end

    bus.if_gnt = if_gnt_s;
    bus.dm_gnt = dm_gnt_s;
    bus.mem_en = if_gnt_s | dm_gnt_s;
    bus.mem_we = dm_gnt_s & bus.dm_we;

    if (dm_gnt_s) begin
      bus.mem_addr  = bus.dm_addr;
      bus.mem_wdata = bus.dm_wdata;
    end else if (if_gnt_s) begin
      bus.mem_addr  = bus.if_addr;
      bus.mem_wdata = {DATA_W{1'b0}};
    end else begin
      bus.mem_addr  = {ADDR_W{1'b0}};
      bus.mem_wdata = {DATA_W{1'b0}};
    end

    bus.if_rvalid = (rd_owner_q == OWN_IF);
    bus.dm_rvalid = (rd_owner_q == OWN_DM);
    if (rd_owner_q == OWN_IF) begin
      bus.if_rdata = bus.mem_rdata;
    end else begin
      bus.if_rdata = {DATA_W{1'b0}};
    end
    if (rd_owner_q == OWN_DM) begin
      bus.dm_rdata = bus.mem_rdata;
    end else begin
      bus.dm_rdata = {DATA_W{1'b0}};
    end
  end

endmodule
